// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: register address type, x0 constant,
// write-source selector and the hazard address-compare helper.
package wb_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LSU,
    WB_SKID,
    WB_IEU
  } wb_src_e;

  // x0 is hardwired, so a read of it never waits on anything.
  function automatic logic reg_hit(input reg_addr_t rs, input reg_addr_t rd);
    return (rs != REG_ZERO) && (rs == rd);
  endfunction

endpackage

// File: rtl/wb_lq_fifo.sv
// In-order FIFO of destination tags for loads still waiting on LSU data,
// with a per-entry compare against two decode read addresses.
module lq_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  reg_addr_t        i_push_tag,
  input  logic             i_pop,
  input  reg_addr_t        i_q1_addr,
  input  reg_addr_t        i_q2_addr,
  output logic             o_full,
  output logic             o_empty,
  output reg_addr_t        o_head_tag,
  output logic [DEPTH-1:0] o_match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [DEPTH-1:0] r_vld;
  reg_addr_t        r_tags [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_tag = r_tags[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) r_tags[i] <= REG_ZERO;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_tags[r_wr_ptr] <= i_push_tag;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = r_vld[i] &&
                   (reg_hit(i_q1_addr, r_tags[i]) || reg_hit(i_q2_addr, r_tags[i]));
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: merges IEU results and in-order LSU load data onto the
// single register-file write port, and flags RAW hazards for decode.
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ieu_valid,
  output logic            ieu_ready,
  input  logic [4:0]      ieu_rd,
  input  logic [XLEN-1:0] ieu_data,
  input  logic            load_issue_valid,
  output logic            load_issue_ready,
  input  logic [4:0]      load_issue_rd,
  input  logic            lsu_resp_valid,
  input  logic [XLEN-1:0] lsu_resp_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs_hazard,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic            r_skid_vld;
  reg_addr_t       r_skid_rd;
  logic [XLEN-1:0] r_skid_data;

  logic                w_lq_full;
  logic                w_lq_empty;
  reg_addr_t           w_lq_head;
  logic [LQ_DEPTH-1:0] w_lq_match;

  logic            w_ieu_take;
  logic            w_lsu_fire;
  logic            w_resp_err;
  wb_src_e         w_src;
  reg_addr_t       w_wb_addr;
  logic [XLEN-1:0] w_wb_data;
  logic            w_skid_load;
  logic            w_skid_clear;

  lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk        (clk),
    .rst        (rst),
    .i_push     (load_issue_valid),
    .i_push_tag (load_issue_rd),
    .i_pop      (lsu_resp_valid),
    .i_q1_addr  (rs1_addr),
    .i_q2_addr  (rs2_addr),
    .o_full     (w_lq_full),
    .o_empty    (w_lq_empty),
    .o_head_tag (w_lq_head),
    .o_match    (w_lq_match)
  );

  assign ieu_ready        = !r_skid_vld;
  assign load_issue_ready = !w_lq_full;

  // x0 results are accepted but never reach the skid or the write port.
  assign w_ieu_take = ieu_valid && ieu_ready && (ieu_rd != REG_ZERO);
  assign w_lsu_fire = lsu_resp_valid && !w_lq_empty;
  assign w_resp_err = lsu_resp_valid && w_lq_empty;

  always_comb begin
    w_src        = WB_NONE;
    w_wb_addr    = REG_ZERO;
    w_wb_data    = '0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (w_lsu_fire) begin
      w_src       = WB_LSU;
      w_wb_addr   = w_lq_head;
      w_wb_data   = lsu_resp_data;
      w_skid_load = w_ieu_take;
    end else if (r_skid_vld) begin
      w_src        = WB_SKID;
      w_wb_addr    = r_skid_rd;
      w_wb_data    = r_skid_data;
      w_skid_clear = 1'b1;
    end else if (w_ieu_take) begin
      w_src     = WB_IEU;
      w_wb_addr = ieu_rd;
      w_wb_data = ieu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_vld  <= 1'b0;
      r_skid_rd   <= REG_ZERO;
      r_skid_data <= '0;
    end else if (w_skid_load) begin
      r_skid_vld  <= 1'b1;
      r_skid_rd   <= ieu_rd;
      r_skid_data <= ieu_data;
    end else if (w_skid_clear) begin
      r_skid_vld  <= 1'b0;
    end
  end

  // Address/data hold their last write; only rd_we is a per-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_we   <= 1'b0;
      rd_addr <= REG_ZERO;
      rd_data <= '0;
    end else if ((w_src != WB_NONE) && (w_wb_addr != REG_ZERO)) begin
      rd_we   <= 1'b1;
      rd_addr <= w_wb_addr;
      rd_data <= w_wb_data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  // The output register counts too: the sync register file cannot forward it.
  assign rs_hazard = (|w_lq_match) ||
                     (r_skid_vld && (reg_hit(rs1_addr, r_skid_rd) || reg_hit(rs2_addr, r_skid_rd))) ||
                     (rd_we && (reg_hit(rs1_addr, rd_addr) || reg_hit(rs2_addr, rd_addr)));

  a_resp_needs_load : assert property (@(posedge clk) disable iff (rst) !w_resp_err)
    else $warning("wb_unit: lsu_resp_valid with empty load queue, response ignored");

endmodule

// File: tb/tb_wb_unit.sv
// Directed and randomized bench for wb_unit against a queue-based model.
module tb_wb_unit;

  localparam int XLEN = 32;
  localparam int LQD  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ieu_valid, ieu_ready;
  logic [4:0]      ieu_rd;
  logic [XLEN-1:0] ieu_data;
  logic            load_issue_valid, load_issue_ready;
  logic [4:0]      load_issue_rd;
  logic            lsu_resp_valid;
  logic [XLEN-1:0] lsu_resp_data;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs_hazard;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding load tags, pending IEU result, last write.
  logic [4:0]      tq[$];
  bit              sk_v;
  logic [4:0]      sk_rd;
  logic [XLEN-1:0] sk_data;
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;

  wb_unit #(.XLEN(XLEN), .LQ_DEPTH(LQD)) dut (
    .clk(clk), .rst(rst),
    .ieu_valid(ieu_valid), .ieu_ready(ieu_ready), .ieu_rd(ieu_rd), .ieu_data(ieu_data),
    .load_issue_valid(load_issue_valid), .load_issue_ready(load_issue_ready),
    .load_issue_rd(load_issue_rd),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_hazard(rs_hazard),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    tq.delete();
    sk_v   = 0;
    m_we   = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic idle_inputs();
    ieu_valid = 0; ieu_rd = '0; ieu_data = '0;
    load_issue_valid = 0; load_issue_rd = '0;
    lsu_resp_valid = 0; lsu_resp_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  // One clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    bit lsu, ieu_acc, iss;
    int qn;
    logic [4:0] tag;
    @(posedge clk);
    qn      = tq.size();
    lsu     = lsu_resp_valid && (qn > 0);
    ieu_acc = ieu_valid && !sk_v && (ieu_rd != 0);
    iss     = load_issue_valid && (qn < LQD);
    m_we    = 0;
    if (lsu) begin
      tag = tq.pop_front();
      if (tag != 0) begin m_we = 1; m_addr = tag; m_data = lsu_resp_data; end
      if (ieu_acc) begin sk_v = 1; sk_rd = ieu_rd; sk_data = ieu_data; end
    end else if (sk_v) begin
      m_we = 1; m_addr = sk_rd; m_data = sk_data; sk_v = 0;
    end else if (ieu_acc) begin
      m_we = 1; m_addr = ieu_rd; m_data = ieu_data;
    end
    if (iss) tq.push_back(load_issue_rd);
    #1;
  endtask

  function automatic bit exp_hazard(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] rs [2];
    rs[0] = a; rs[1] = b;
    for (int k = 0; k < 2; k++) begin
      if (rs[k] != 0) begin
        foreach (tq[i]) if (tq[i] == rs[k]) return 1;
        if (sk_v && sk_rd == rs[k]) return 1;
        if (m_we && m_addr == rs[k]) return 1;
      end
    end
    return 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #1 rst = 1;
    #1;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rd_we); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rd_data); end
    repeat (2) @(posedge clk);
    #2 rst = 0;
    model_reset();
    rs1_addr = 5'd5;
    #1;
    checks++; if (ieu_ready !== 1'b1) begin errors++; $display("FAIL reset_ieu_ready: got %b want 1", ieu_ready); end
    checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_lq_ready: got %b want 1", load_issue_ready); end
    checks++; if (rs_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", rs_hazard); end
    rs1_addr = '0;
  endtask

  task automatic test_ieu_only();
    ieu_valid = 1; ieu_rd = 5'd5; ieu_data = 32'h1234;
    #1;
    checks++; if (ieu_ready !== 1'b1) begin errors++; $display("FAIL ieu_ready_pre: got %b want 1", ieu_ready); end
    tick();
    ieu_valid = 0;
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234) begin
      errors++; $display("FAIL ieu_write: got we=%b r%0d=%h want we=1 r5=1234", rd_we, rd_addr, rd_data);
    end
    checks++; if (ieu_ready !== 1'b1) begin errors++; $display("FAIL ieu_ready_post: got %b want 1", ieu_ready); end
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL ieu_pulse: got %b want 0", rd_we); end
  endtask

  task automatic test_collision();
    load_issue_valid = 1; load_issue_rd = 5'd7;
    tick();
    load_issue_valid = 0;
    ieu_valid = 1; ieu_rd = 5'd3; ieu_data = 32'hA;
    lsu_resp_valid = 1; lsu_resp_data = 32'hB;
    tick();
    ieu_valid = 0; lsu_resp_valid = 0;
    #1;
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hB) begin
      errors++; $display("FAIL coll_lsu_first: got we=%b r%0d=%h want we=1 r7=b", rd_we, rd_addr, rd_data);
    end
    checks++; if (ieu_ready !== 1'b0) begin errors++; $display("FAIL coll_skid_full: got ready=%b want 0", ieu_ready); end
    tick();
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'hA) begin
      errors++; $display("FAIL coll_skid_drain: got we=%b r%0d=%h want we=1 r3=a", rd_we, rd_addr, rd_data);
    end
    checks++; if (ieu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_back: got %b want 1", ieu_ready); end
    tick();
  endtask

  task automatic test_queue_full();
    for (int k = 1; k <= 4; k++) begin
      load_issue_valid = 1; load_issue_rd = 5'(k);
      #1;
      checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL lq_ready_fill%0d: got %b want 1", k, load_issue_ready); end
      tick();
    end
    load_issue_valid = 0;
    #1;
    checks++; if (load_issue_ready !== 1'b0) begin errors++; $display("FAIL lq_full: got ready=%b want 0", load_issue_ready); end
    lsu_resp_valid = 1; lsu_resp_data = 32'h11;
    tick();
    lsu_resp_valid = 0;
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h11) begin
      errors++; $display("FAIL lq_resp1: got we=%b r%0d=%h want r1=11", rd_we, rd_addr, rd_data);
    end
    checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL lq_ready_after_pop: got %b want 1", load_issue_ready); end
    // Push and pop together at count 3: write pointer wraps to slot 0.
    load_issue_valid = 1; load_issue_rd = 5'd5;
    lsu_resp_valid = 1; lsu_resp_data = 32'h22;
    tick();
    load_issue_valid = 0; lsu_resp_valid = 0;
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'h22) begin
      errors++; $display("FAIL lq_pushpop: got we=%b r%0d=%h want r2=22", rd_we, rd_addr, rd_data);
    end
    checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL lq_pushpop_ready: got %b want 1", load_issue_ready); end
    for (int k = 3; k <= 5; k++) begin
      lsu_resp_valid = 1; lsu_resp_data = 32'(k * 32'h11);
      tick();
      checks++; if (rd_we !== 1'b1 || rd_addr !== 5'(k) || rd_data !== 32'(k * 32'h11)) begin
        errors++; $display("FAIL lq_resp%0d: got we=%b r%0d=%h want r%0d=%h", k, rd_we, rd_addr, rd_data, k, k * 32'h11);
      end
    end
    lsu_resp_valid = 0;
    tick();
  endtask

  task automatic test_hazard();
    load_issue_valid = 1; load_issue_rd = 5'd9;
    tick();
    load_issue_valid = 0; rs1_addr = 5'd9;
    #1;
    checks++; if (rs_hazard !== 1'b1) begin errors++; $display("FAIL haz_pending: got %b want 1", rs_hazard); end
    lsu_resp_valid = 1; lsu_resp_data = 32'h99;
    #1;
    checks++; if (rs_hazard !== 1'b1) begin errors++; $display("FAIL haz_resp_cycle: got %b want 1", rs_hazard); end
    tick();
    lsu_resp_valid = 0;
    #1;
    checks++; if (rd_we !== 1'b1 || rd_addr !== 5'd9 || rs_hazard !== 1'b1) begin
      errors++; $display("FAIL haz_write_cycle: got we=%b r%0d haz=%b want we=1 r9 haz=1", rd_we, rd_addr, rs_hazard);
    end
    tick();
    checks++; if (rs_hazard !== 1'b0) begin errors++; $display("FAIL haz_clear: got %b want 0", rs_hazard); end
    rs1_addr = 5'd0;
    load_issue_valid = 1; load_issue_rd = 5'd0;
    tick();
    load_issue_valid = 0; rs2_addr = 5'd0;
    #1;
    checks++; if (rs_hazard !== 1'b0) begin errors++; $display("FAIL haz_x0: got %b want 0", rs_hazard); end
    lsu_resp_valid = 1; lsu_resp_data = 32'hDEAD;
    tick();
    lsu_resp_valid = 0;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL x0_load_write: got we=%b want 0", rd_we); end
  endtask

  task automatic test_x0_error();
    ieu_valid = 1; ieu_rd = 5'd0; ieu_data = 32'h55;
    tick();
    ieu_valid = 0;
    checks++; if (rd_we !== 1'b0 || ieu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ieu: got we=%b ready=%b want we=0 ready=1", rd_we, ieu_ready);
    end
    lsu_resp_valid = 1; lsu_resp_data = 32'h77;
    #1;
    checks++; if (dut.w_resp_err !== 1'b1) begin errors++; $display("FAIL empty_resp_flag: got %b want 1", dut.w_resp_err); end
    tick();
    lsu_resp_valid = 0;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL empty_resp_write: got we=%b want 0", rd_we); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ieu_valid        = 1'($urandom % 2);
      ieu_rd           = 5'($urandom % 8);
      ieu_data         = $urandom;
      load_issue_valid = 1'($urandom % 2);
      load_issue_rd    = 5'($urandom % 8);
      lsu_resp_valid   = (tq.size() > 0) && ($urandom % 3 != 0);
      lsu_resp_data    = $urandom;
      rs1_addr         = 5'($urandom % 8);
      rs2_addr         = 5'($urandom % 8);
      #1;
      checks++; if (ieu_ready !== !sk_v) begin errors++; $display("FAIL rnd_ieu_ready[%0d]: got %b want %b", n, ieu_ready, !sk_v); end
      checks++; if (load_issue_ready !== (tq.size() < LQD)) begin
        errors++; $display("FAIL rnd_lq_ready[%0d]: got %b want %b", n, load_issue_ready, tq.size() < LQD);
      end
      checks++; if (rs_hazard !== exp_hazard(rs1_addr, rs2_addr)) begin
        errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", n, rs_hazard, exp_hazard(rs1_addr, rs2_addr));
      end
      tick();
      checks++; if (rd_we !== m_we) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", n, rd_we, m_we); end
      if (m_we) begin
        checks++; if (rd_addr !== m_addr || rd_data !== m_data) begin
          errors++; $display("FAIL rnd_write[%0d]: got r%0d=%h want r%0d=%h", n, rd_addr, rd_data, m_addr, m_data);
        end
      end
    end
    idle_inputs();
    repeat (8) begin
      lsu_resp_valid = (tq.size() > 0);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 10; k <= 12; k++) begin
      load_issue_valid = 1; load_issue_rd = 5'(k);
      tick();
    end
    load_issue_valid = 0;
    ieu_valid = 1; ieu_rd = 5'd13; ieu_data = 32'hD;
    lsu_resp_valid = 1; lsu_resp_data = 32'hC;
    tick();
    ieu_valid = 0; lsu_resp_valid = 0; rs1_addr = 5'd11;
    #1;
    checks++; if (rs_hazard !== 1'b1 || ieu_ready !== 1'b0 || rd_we !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got haz=%b ready=%b we=%b want 1 0 1", rs_hazard, ieu_ready, rd_we);
    end
    rst = 1;
    #1;
    checks++; if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== '0) begin
      errors++; $display("FAIL mid_rst_outputs: got we=%b r%0d=%h want all zero", rd_we, rd_addr, rd_data);
    end
    checks++; if (rs_hazard !== 1'b0 || ieu_ready !== 1'b1 || load_issue_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_status: got haz=%b ieu_rdy=%b lq_rdy=%b want 0 1 1", rs_hazard, ieu_ready, load_issue_ready);
    end
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    rs1_addr = 5'd0;
    lsu_resp_valid = 1; lsu_resp_data = 32'h88;
    #1;
    checks++; if (dut.w_resp_err !== 1'b1) begin errors++; $display("FAIL mid_empty_flag: got %b want 1", dut.w_resp_err); end
    tick();
    lsu_resp_valid = 0;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL mid_empty_write: got we=%b want 0", rd_we); end
  endtask

  initial begin
    test_reset();
    test_ieu_only();
    test_collision();
    test_queue_full();
    test_hazard();
    test_x0_error();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
